mask_pattern_gen: RTL
=====================

MASK_PATTERN_GEN -- requirements
Module: mask_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 64, active pixels per line.
REQ-002 SHALL have parameter H_FP / H_SYNC / H_BP, defaults 5 / 9 / 5, giving H_SIZE = 83 total clocks per line.
REQ-003 SHALL have parameter V_ACTIVE, default 64, active lines per frame.
REQ-004 SHALL have parameter V_FP / V_SYNC / V_BP, defaults 2 / 3 / 3, giving 72 total lines per frame.
REQ-005 SHALL have parameter SQ_SIZE, default 16, edge length of the centred square pattern.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  1  run request; sampled every cycle.
REQ-009 pattern  input  2  pattern select: 0 = zero, 1 = ones, 2 = 8x8 checkerboard, 3 = centred square.
REQ-010 de_out  output  1  data enable, high on active pixels.
REQ-011 hsync_out  output  1  horizontal sync, active-high.
REQ-012 vsync_out  output  1  vertical sync, active-high.
REQ-013 pixel_out  output  24  mask as {8{m},8{m},8{m}}; pixel_out[0] is the mask bit m.
REQ-014 frame_start  output  1  one-cycle pulse coincident with the first active pixel (x=0, y=0).
REQ-015 busy  output  1  high while in RUN or DRAIN state.

Function
REQ-016 SHALL hold horizontal counter hc (0..H_SIZE-1) and vertical counter vc (0..V_SIZE-1); hc wraps to 0 at H_SIZE-1 and vc increments on that wrap; vc wraps to 0 at V_SIZE-1.
REQ-017 Line layout SHALL be: hc < H_ACTIVE active, then H_FP, then H_SYNC (hsync high), then H_BP; the vertical layout SHALL be analogous with vsync high for V_SYNC whole lines.
REQ-018 de_out SHALL be high exactly when hc < H_ACTIVE and vc < V_ACTIVE.
REQ-019 All outputs SHALL be registered, with 1-cycle latency from the counters; de, hsync, vsync and pixel SHALL be mutually aligned.
REQ-020 pixel_out SHALL be 24'h0 whenever de_out is low.
REQ-021 Pattern 2 SHALL give m = x[3] XOR y[3]. Pattern 3 SHALL give m = 1 for x and y both in [(ACTIVE-SQ_SIZE)/2, (ACTIVE+SQ_SIZE)/2).
REQ-022 pattern SHALL be latched only at the frame boundary (hc=0, vc=0) and held constant for the whole frame.
REQ-023 FSM SHALL have states IDLE, RUN and DRAIN.
REQ-024 IDLE: counters held at 0 and outputs low; en=1 moves to RUN, starting at hc=vc=0 on the next cycle.
REQ-025 RUN: counters advance; en=0 moves to DRAIN.
REQ-026 DRAIN: the current frame completes; at wrap to hc=vc=0 the FSM goes to IDLE if en=0, or back to RUN if en=1 (no gap between frames).
REQ-027 en toggling within a frame SHALL never truncate a frame.

Reset
REQ-028 rst SHALL force: FSM to IDLE, hc=vc=0, latched pattern=0, LFSR to seed 16'hACE1, and all outputs 0 on the next edge.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately; rst has priority over en.

Configuration
REQ-030 With MASK_NOISE_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance on each active pixel, and m SHALL be inverted when lfsr[7:0] == 8'h00 (salt-and-pepper for median filter testing).
REQ-031 Without MASK_NOISE_EN, no LFSR SHALL exist and the mask SHALL be the pure pattern.

Structure
REQ-032 A shared package SHALL hold the pattern-select encoding constants, the FSM state typedef, and the LFSR seed/taps.
REQ-033 One sub-module, video_timing_cnt, SHALL own hc/vc and the de/hsync/vsync decode; mask_pattern_gen SHALL own the FSM, pattern logic and LFSR.

Verification
REQ-034 Reset, then en=1, pattern=1, defaults: de_out high for 64 clocks per line on 64 lines; frame period 83*72 = 5976 clocks; frame_start every 5976 clocks.
REQ-035 Pattern=2: pixel_out = 24'hFFFFFF at (x=8,y=0), 24'h0 at (x=8,y=8), 24'h0 at (0,0); hsync_out high for 9 clocks starting 5 clocks after de_out falls.
REQ-036 Pattern=3, SQ_SIZE=16: ones count per frame = 256; only rows and columns 24..39 are set.
REQ-037 en dropped at pixel (10,5): the frame completes to 5976 clocks, then busy=0 and outputs stay 0; pattern changed mid-frame takes effect only on the next frame.
REQ-038 rst pulsed at vc=30: all outputs 0 on the next edge; after release with en=1, frame_start occurs 1 cycle after RUN entry.
REQ-039 MASK_NOISE_EN defined, pattern=0: ones count per frame is nonzero and matches the reference LFSR model from seed 16'hACE1.

Source files
------------

// File: rtl/mask_pattern_gen_pkg.sv
// Shared constants for the mask pattern generator: pattern encodings, FSM states, LFSR seed/taps.
// The LFSR helper is only consumed when MASK_NOISE_EN is defined.
package mask_pattern_gen_pkg;

  localparam logic [1:0] PAT_ZERO    = 2'd0;
  localparam logic [1:0] PAT_ONES    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_SQUARE  = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mask_pattern_gen_if.sv
// Control and video bus of the mask pattern generator; master drives run/pattern, slave drives video.
interface mask_pattern_gen_if;
  logic        en;
  logic [1:0]  pattern;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [23:0] pixel_out;
  logic        frame_start;
  logic        busy;

  modport master (output en, pattern,
                  input  de_out, hsync_out, vsync_out, pixel_out, frame_start, busy);
  modport slave  (input  en, pattern,
                  output de_out, hsync_out, vsync_out, pixel_out, frame_start, busy);
endinterface

// File: rtl/mask_pattern_gen_video_timing_cnt.sv
// Raster counters plus combinational de/hsync/vsync decode; counters sit at 0 whenever adv_i is low.
module video_timing_cnt #(
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 5,
  parameter int H_SYNC   = 9,
  parameter int H_BP     = 5,
  parameter int V_ACTIVE = 64,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 3,
  localparam int H_SIZE  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_SIZE  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_SIZE),
  localparam int VW      = $clog2(V_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv_i,
  output logic [HW-1:0] hc_o,
  output logic [VW-1:0] vc_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          sof_o,
  output logic          eof_o
);

  localparam logic [HW-1:0] H_LAST = HW'(H_SIZE - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_SIZE - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic          h_wrap;

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    hc_d   = '0;
    vc_d   = '0;
    if (adv_i) begin
      hc_d = h_wrap ? '0 : hc_q + 1'b1;
      vc_d = vc_q;
      if (h_wrap) vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o    = hc_q;
  assign vc_o    = vc_q;
  assign de_o    = (hc_q < H_ACT) && (vc_q < V_ACT);
  assign hsync_o = (hc_q >= HS_BEG) && (hc_q < HS_END);
  assign vsync_o = (vc_q >= VS_BEG) && (vc_q < VS_END);
  assign sof_o   = (hc_q == '0) && (vc_q == '0);
  assign eof_o   = h_wrap && (vc_q == V_LAST);

endmodule

// File: rtl/mask_pattern_gen.sv
// Mask pattern generator: run/drain FSM, per-frame pattern latch and registered video outputs.
// Define MASK_NOISE_EN to add LFSR salt-and-pepper inversion of the mask.
module mask_pattern_gen
  import mask_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 5,
  parameter int H_SYNC   = 9,
  parameter int H_BP     = 5,
  parameter int V_ACTIVE = 64,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 3,
  parameter int SQ_SIZE  = 16
) (
  input  logic               clk,
  input  logic               rst,
  mask_pattern_gen_if.slave  bus
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [HW-1:0] SQ_X0 = HW'((H_ACTIVE - SQ_SIZE) / 2);
  localparam logic [HW-1:0] SQ_X1 = HW'((H_ACTIVE + SQ_SIZE) / 2);
  localparam logic [VW-1:0] SQ_Y0 = VW'((V_ACTIVE - SQ_SIZE) / 2);
  localparam logic [VW-1:0] SQ_Y1 = VW'((V_ACTIVE + SQ_SIZE) / 2);

  state_t        state_q, state_d;
  logic          run;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          de, hs, vs, sof, eof;
  logic [1:0]    pat_q, pat_sel;
  logic          m_pat, m;
  logic          de_q, hs_q, vs_q, fs_q;
  logic [23:0]   pix_q;

  assign run = (state_q != ST_IDLE);

  video_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tim (
    .clk(clk), .rst(rst), .adv_i(run),
    .hc_o(hc), .vc_o(vc), .de_o(de), .hsync_o(hs), .vsync_o(vs),
    .sof_o(sof), .eof_o(eof)
  );

  // A frame, once started, always runs to its last pixel; en is only honoured at the wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.en)  state_d = ST_RUN;
      ST_RUN:   if (!bus.en) state_d = eof ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (eof)     state_d = bus.en ? ST_RUN : ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // The first pixel of a frame uses the live select; the rest of the frame uses the latched copy.
  assign pat_sel = sof ? bus.pattern : pat_q;

  always_comb begin
    case (pat_sel)
      PAT_ZERO:    m_pat = 1'b0;
      PAT_ONES:    m_pat = 1'b1;
      PAT_CHECKER: m_pat = hc[3] ^ vc[3];
      default:     m_pat = (hc >= SQ_X0) && (hc < SQ_X1) && (vc >= SQ_Y0) && (vc < SQ_Y1);
    endcase
  end

`ifdef MASK_NOISE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst)             lfsr_q <= LFSR_SEED;
    else if (run && de)  lfsr_q <= lfsr_next(lfsr_q);
  end

  assign m = m_pat ^ (lfsr_q[7:0] == 8'h00);
`else
  assign m = m_pat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_ZERO;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      if (sof) pat_q <= bus.pattern;
      de_q    <= run && de;
      hs_q    <= run && hs;
      vs_q    <= run && vs;
      fs_q    <= run && sof;
      pix_q   <= (run && de) ? {24{m}} : 24'h0;
    end
  end

  assign bus.de_out      = de_q;
  assign bus.hsync_out   = hs_q;
  assign bus.vsync_out   = vs_q;
  assign bus.pixel_out   = pix_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = run;

endmodule
